// File: rtl/tl_pkg.sv
// Shared types for the traffic-light controller and its manual-override request generator.
package tl_pkg;

    typedef enum logic [3:0] {
        S0_A_STRAIGHT     = 4'd0,
        S1_A_STRAIGHT_YEL = 4'd1,
        S2_A_LEFT         = 4'd2,
        S3_A_LEFT_YEL     = 4'd3,
        S4_B_STRAIGHT     = 4'd4,
        S5_B_STRAIGHT_YEL = 4'd5,
        S6_B_LEFT         = 4'd6,
        S7_B_LEFT_YEL     = 4'd7,
        S8_OVERRIDE       = 4'd8,
        S9_ALL_RED        = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKED  = 2'd2
    } ovr_st_t;

    function automatic state_t btn_to_phase(input logic [1:0] idx);
        state_t ph;
        case (idx)
            2'd0:    ph = S0_A_STRAIGHT;
            2'd1:    ph = S2_A_LEFT;
            2'd2:    ph = S4_B_STRAIGHT;
            default: ph = S6_B_LEFT;
        endcase
        return ph;
    endfunction

    function automatic logic is_green(input state_t s);
        return (s == S0_A_STRAIGHT) || (s == S2_A_LEFT) ||
               (s == S4_B_STRAIGHT) || (s == S6_B_LEFT);
    endfunction

endpackage

// File: rtl/tl_override_req_if.sv
// Jump handshake between the override request generator (master) and tl_fsm (slave).
interface tl_override_req_if;

    logic            jump_req;
    tl_pkg::state_t  jump_state;
    logic            accept_jump;
    tl_pkg::state_t  cur_state;
    logic            busy;
    logic            err_accept;

    modport master (
        output jump_req,
        output jump_state,
        output busy,
        output err_accept,
        input  accept_jump,
        input  cur_state
    );

    modport slave (
        input  jump_req,
        input  jump_state,
        input  busy,
        input  err_accept,
        output accept_jump,
        output cur_state
    );

endinterface

// File: rtl/tl_debounce.sv
// One button path: 2-flop synchronizer, counter debouncer, rising-edge pulse.
module tl_debounce #(
    parameter int unsigned DB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din_async,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DB_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d, deb_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The DB_CYC-th consecutive disagreeing cycle commits the new level.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CW'(DB_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= din_async;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    assign level = deb_q;
    assign rise  = deb_q & ~deb_prev_q;

endmodule

// File: rtl/tl_override_req.sv
// Manual-override request generator: debounced buttons become a held jump request for tl_fsm.
module tl_override_req
    import tl_pkg::*;
#(
    parameter int unsigned F_CLK_HZ    = 50_000_000,
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           btn,
    tl_override_req_if.master    ovr
);

    localparam int unsigned DB_CYC = (F_CLK_HZ / 1000) * DEBOUNCE_MS;

    if (DB_CYC < 1) begin : g_db_check
        $error("tl_override_req: DB_CYC must be at least 1");
    end

    logic [3:0] press;
    logic [3:0] level;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        tl_debounce #(
            .DB_CYC (DB_CYC)
        ) u_debounce (
            .clk       (clk),
            .rst_n     (rst_n),
            .din_async (btn[i]),
            .level     (level[i]),
            .rise      (press[i])
        );
    end

    logic unused_level;
    assign unused_level = ^level;

    // Lowest index wins; a press for the phase already running is meaningless.
    state_t sel_phase;
    logic   press_valid;

    always_comb begin
        sel_phase = S0_A_STRAIGHT;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) begin
                sel_phase = btn_to_phase(2'(i));
            end
        end
        press_valid = (|press) && (sel_phase != ovr.cur_state);
    end

    ovr_st_t st_q, st_d;
    logic    jump_req_q, jump_req_d;
    state_t  jump_state_q, jump_state_d;
    logic    busy_q, busy_d;
    logic    err_q, err_d;

    // jump_state stays frozen after accept: tl_fsm samples it only when leaving S8_OVERRIDE.
    always_comb begin
        st_d         = st_q;
        jump_req_d   = jump_req_q;
        jump_state_d = jump_state_q;
        err_d        = err_q;
        unique case (st_q)
            IDLE: begin
                if (ovr.accept_jump) begin
                    err_d = 1'b1;
                end else if (press_valid) begin
                    st_d         = PENDING;
                    jump_req_d   = 1'b1;
                    jump_state_d = sel_phase;
                end
            end
            PENDING: begin
                if (ovr.accept_jump) begin
                    st_d       = LOCKED;
                    jump_req_d = 1'b0;
                end else if (press_valid && (sel_phase != jump_state_q)) begin
                    jump_state_d = sel_phase;
                end
            end
            LOCKED: begin
                if (ovr.accept_jump) begin
                    err_d = 1'b1;
                end
                if (is_green(ovr.cur_state)) begin
                    st_d = IDLE;
                end
            end
            default: begin
                st_d       = IDLE;
                jump_req_d = 1'b0;
            end
        endcase
        busy_d = (st_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= IDLE;
            jump_req_q   <= 1'b0;
            jump_state_q <= S0_A_STRAIGHT;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            st_q         <= st_d;
            jump_req_q   <= jump_req_d;
            jump_state_q <= jump_state_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign ovr.jump_req   = jump_req_q;
    assign ovr.jump_state = jump_state_q;
    assign ovr.busy       = busy_q;
    assign ovr.err_accept = err_q;

endmodule
